// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, samples the
// synchronized columns once per scan tick and debounces both press and
// release before reporting a key index.
module keypad_scan #(
    parameter int SCAN_DIV     = 25000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]       CNT_LAST = 8'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Active-low one-cold row drive for a row index
    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            2'd3:    drv = 4'b0111;
            default: drv = 4'b1110;
        endcase
        return drv;
    endfunction

    logic [3:0]       sync_meta_r;
    logic [3:0]       col_s_r;
    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_nxt_s;
    logic [1:0]       row_idx_r;
    logic [3:0]       row_n_r;
    logic [3:0]       cand_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic             key_down_r;
    logic             any_low_s;
    logic [1:0]       low_col_s;
    logic             cand_low_s;
    logic             adv_row_s;
    logic             latch_cand_s;
    logic             accept_s;
    logic             release_s;

    assign tick_s     = (div_r == DIV_LAST);
    assign cand_low_s = ~col_s_r[cand_r[1:0]];

    assign row_n     = row_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_down  = key_down_r;

    // Two-flop synchronizer for the asynchronous column inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 4'b1111;
            col_s_r     <= 4'b1111;
        end else begin
            sync_meta_r <= col_n;
            col_s_r     <= sync_meta_r;
        end
    end

    // Free-running scan-tick divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Lowest-index active column wins when several are pressed
    always_comb begin
        any_low_s = 1'b1;
        low_col_s = 2'd0;
        if (!col_s_r[0]) begin
            low_col_s = 2'd0;
        end else if (!col_s_r[1]) begin
            low_col_s = 2'd1;
        end else if (!col_s_r[2]) begin
            low_col_s = 2'd2;
        end else if (!col_s_r[3]) begin
            low_col_s = 2'd3;
        end else begin
            any_low_s = 1'b0;
            low_col_s = 2'd0;
        end
    end

    // Next-state and control decode; the FSM only moves on scan ticks
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        adv_row_s    = 1'b0;
        latch_cand_s = 1'b0;
        accept_s     = 1'b0;
        release_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                SCAN: begin
                    if (any_low_s) begin
                        latch_cand_s = 1'b1;
                        state_nxt_s  = DEBOUNCE;
                        cnt_nxt_s    = 8'd0;
                    end else begin
                        adv_row_s = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (cand_low_s) begin
                        if (cnt_r == CNT_LAST) begin
                            state_nxt_s = HELD;
                            cnt_nxt_s   = 8'd0;
                            accept_s    = 1'b1;
                        end else begin
                            cnt_nxt_s = cnt_r + 8'd1;
                        end
                    end else begin
                        state_nxt_s = SCAN;
                        cnt_nxt_s   = 8'd0;
                        adv_row_s   = 1'b1;
                    end
                end
                HELD: begin
                    if (!cand_low_s) begin
                        state_nxt_s = RELEASE;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = HELD;
                    end
                end
                RELEASE: begin
                    if (cand_low_s) begin
                        state_nxt_s = HELD;
                        cnt_nxt_s   = 8'd0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_nxt_s = SCAN;
                        cnt_nxt_s   = 8'd0;
                        adv_row_s   = 1'b1;
                        release_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = SCAN;
                    cnt_nxt_s   = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end
    end

    // FSM state and debounce counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SCAN;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Row rotation and candidate key latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx_r <= 2'd0;
            row_n_r   <= 4'b1110;
            cand_r    <= 4'd0;
        end else begin
            if (adv_row_s) begin
                row_idx_r <= row_idx_r + 2'd1;
                row_n_r   <= row_drive(row_idx_r + 2'd1);
            end else begin
                row_idx_r <= row_idx_r;
                row_n_r   <= row_n_r;
            end
            if (latch_cand_s) begin
                cand_r <= {row_idx_r, low_col_s};
            end else begin
                cand_r <= cand_r;
            end
        end
    end

    // Registered key reporting: one-clock valid pulse, held-key level, sticky code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_down_r  <= 1'b0;
        end else begin
            key_valid_r <= accept_s;
            if (accept_s) begin
                key_code_r <= cand_r;
                key_down_r <= 1'b1;
            end else if (release_s) begin
                key_down_r <= 1'b0;
            end else begin
                key_down_r <= key_down_r;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a physical keypad model drives col_n
// from row_n, a tick-level reference model predicts accepted keys into a
// scoreboard queue, and a monitor pops and compares on every key_valid.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;

    localparam int PH_SCAN = 0;
    localparam int PH_CONF = 1;
    localparam int PH_HELD = 2;
    localparam int PH_REL  = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    logic [3:0] exp_q[$];

    // reference model of the scanner, one step per scan tick
    int         mrow;
    int         mphase;
    int         mrun;
    int         mcand;
    logic [3:0] mcode;
    logic       mdown;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] row_vec(input int r);
        logic [3:0] v;
        v    = 4'b1111;
        v[r] = 1'b0;
        return v;
    endfunction

    // Physical keypad: a pressed key shorts its column to the driven row
    always @* begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (row_n == row_vec(r)) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest predicted press
    always @(negedge clk) begin
        if (!rst && key_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL key_valid_unexpected actual code=%0d required=no pulse at %0t",
                         key_code, $time);
            end else begin
                check("key_valid_code", {12'd0, key_code}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic model_reset();
        mrow   = 0;
        mphase = PH_SCAN;
        mrun   = 0;
        mcand  = 0;
        mcode  = 4'd0;
        mdown  = 1'b0;
        exp_q.delete();
    endtask

    // One scan tick of the keypad rules, applied to the physical key set
    task automatic model_step();
        int lowest;
        check("pulse_drained", 16'(exp_q.size()), 16'd0);
        case (mphase)
            PH_SCAN: begin
                lowest = -1;
                for (int c = 3; c >= 0; c--) if (pressed[mrow*4+c]) lowest = c;
                if (lowest >= 0) begin
                    mcand  = mrow * 4 + lowest;
                    mphase = PH_CONF;
                    mrun   = 0;
                end else begin
                    mrow = (mrow + 1) % 4;
                end
            end
            PH_CONF: begin
                if (pressed[mcand]) begin
                    mrun++;
                    if (mrun == DEBOUNCE_CNT) begin
                        mphase = PH_HELD;
                        mcode  = 4'(mcand);
                        mdown  = 1'b1;
                        exp_q.push_back(4'(mcand));
                    end
                end else begin
                    mphase = PH_SCAN;
                    mrow   = (mrow + 1) % 4;
                end
            end
            PH_HELD: begin
                if (!pressed[mcand]) begin
                    mphase = PH_REL;
                    mrun   = 0;
                end
            end
            default: begin
                if (pressed[mcand]) begin
                    mphase = PH_HELD;
                end else begin
                    mrun++;
                    if (mrun == DEBOUNCE_CNT) begin
                        mphase = PH_SCAN;
                        mdown  = 1'b0;
                        mrow   = (mrow + 1) % 4;
                    end
                end
            end
        endcase
    endtask

    // Run one scan period, checking every clock, then apply the next key set
    task automatic do_tick(input logic [15:0] nxt);
        for (int k = 1; k <= SCAN_DIV; k++) begin
            @(posedge clk);
            if (k == SCAN_DIV) model_step();
            #1;
            check("row_n", {12'd0, row_n}, {12'd0, row_vec(mrow)});
            if (k == SCAN_DIV) begin
                check("key_down", {15'd0, key_down}, {15'd0, mdown});
                check("key_code", {12'd0, key_code}, {12'd0, mcode});
            end
        end
        pressed = nxt;
    endtask

    // Mid-cycle reset with immediate output checks, then restart the model
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_row_n", {12'd0, row_n}, 16'h000e);
        check("rst_key_valid", {15'd0, key_valid}, 16'd0);
        check("rst_key_down", {15'd0, key_down}, 16'd0);
        check("rst_key_code", {12'd0, key_code}, 16'd0);
        pressed = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Idle until the scanner is about to reach row r, then press keys
    task automatic press_at_row(input int r, input logic [15:0] keys);
        int guard;
        guard = 0;
        while ((mrow != (r + 3) % 4 || mphase != PH_SCAN) && guard < 40) begin
            do_tick(16'd0);
            guard++;
        end
        if (guard >= 40) begin
            checks++;
            failures++;
            $display("FAIL press_at_row_timeout actual row=%0d required=%0d", mrow, (r + 3) % 4);
        end
        do_tick(keys);
    endtask

    initial begin
        int p0;
        logic [15:0] nxt;
        int a;
        int b;
        rst     = 1'b1;
        pressed = 16'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // idle scanning over two full passes
        for (int i = 0; i < 8; i++) do_tick(16'd0);
        check("idle_row_n", {12'd0, row_n}, 16'h000e);
        check("idle_pulses", 16'(pulses), 16'd0);

        // clean press of key 10 in row 2
        press_at_row(2, 16'h0400);
        p0 = pulses;
        for (int i = 0; i < 5; i++) do_tick(16'h0400);
        check("press_code", {12'd0, key_code}, 16'd10);
        check("press_down", {15'd0, key_down}, 16'd1);
        check("press_row_frozen", {12'd0, row_n}, 16'h000b);
        check("press_one_pulse", 16'(pulses - p0), 16'd1);

        // one-tick release glitch keeps the key held
        do_tick(16'h0000);
        do_tick(16'h0400);
        do_tick(16'h0400);
        check("glitch_down", {15'd0, key_down}, 16'd1);
        check("glitch_no_pulse", 16'(pulses - p0), 16'd1);

        // real release, scanning resumes at row 3
        do_tick(16'h0000);
        for (int i = 0; i < 4; i++) do_tick(16'h0000);
        check("release_down", {15'd0, key_down}, 16'd0);
        check("release_row_n", {12'd0, row_n}, 16'h0007);
        check("release_code_kept", {12'd0, key_code}, 16'd10);

        // bounce on key 1 in row 0
        p0 = pulses;
        press_at_row(0, 16'h0002);
        do_tick(16'h0000);
        do_tick(16'h0000);
        check("bounce_row_n", {12'd0, row_n}, 16'h000d);
        check("bounce_no_pulse", 16'(pulses - p0), 16'd0);

        // two keys in row 3: lowest column wins, then reset while held
        press_at_row(3, 16'h9000);
        p0 = pulses;
        for (int i = 0; i < 5; i++) do_tick(16'h9000);
        check("multi_code", {12'd0, key_code}, 16'd12);
        check("multi_down", {15'd0, key_down}, 16'd1);
        check("multi_one_pulse", 16'(pulses - p0), 16'd1);
        do_reset();
        check("held_rst_down", {15'd0, key_down}, 16'd0);
        check("held_rst_row_n", {12'd0, row_n}, 16'h000e);

        // reset mid-debounce aborts without a pulse
        press_at_row(0, 16'h0001);
        do_tick(16'h0001);
        do_tick(16'h0001);
        p0 = pulses;
        do_reset();
        for (int i = 0; i < 6; i++) do_tick(16'd0);
        check("deb_rst_no_pulse", 16'(pulses - p0), 16'd0);

        // randomized key activity against the reference model
        for (int t = 0; t < 400; t++) begin
            nxt = pressed;
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 15);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: nxt = 16'd0;
                    4, 5, 6, 7: nxt = 16'h0001 << a;
                    default:    nxt = (16'h0001 << a) | (16'h0001 << b);
                endcase
            end
            do_tick(nxt);
        end

        for (int i = 0; i < 2; i++) do_tick(16'd0);
        check("final_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
